relobi_rr_mux: RTL and testbench

Reliable OBI round-robin multiplexer that shares one triplicated-handshake OBI manager port between NumSbrPorts requesters. It is the arbitration counterpart of the reliable demux in the relobi interconnect. Arbitration state, the in-order response-routing FIFO and its pointers are held in three replicas, with majority voting every cycle. Voter disagreements and protocol anomalies are reported on fault_o.

---
 rtl/relobi_rr_mux.sv | 221 ++++++++++++++++++++++
 tb/tb_relobi_rr_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/relobi_rr_mux.sv
`default_nettype none
// relobi_rr_mux: round-robin OBI multiplexer with triplicated, majority-voted arbitration
// and response-routing state. Rev 1.0
package obi_pkg;
  typedef struct packed {
    logic        UseRReady;
    logic        Integrity;
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0, Integrity: 1'b0, AddrWidth: 32, DataWidth: 32
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } relobi_a_chan_t;

  typedef struct packed {
    relobi_a_chan_t a;
    logic [2:0]     req;
    logic [2:0]     rready;
  } relobi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } relobi_r_chan_t;

  typedef struct packed {
    relobi_r_chan_t r;
    logic [2:0]     gnt;
    logic [2:0]     rvalid;
  } relobi_rsp_t;
endpackage

module relobi_rr_mux #(
  parameter obi_pkg::obi_cfg_t ObiCfg       = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t    = obi_pkg::relobi_req_t,
  parameter type               obi_rsp_t    = obi_pkg::relobi_rsp_t,
  parameter type               obi_r_chan_t = obi_pkg::relobi_r_chan_t,
  parameter int unsigned       NumSbrPorts  = 2,
  parameter int unsigned       NumMaxTrans  = 4,
  parameter int unsigned       IdxWidth     = $clog2(NumSbrPorts)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  obi_req_t   sbr_ports_req_i [NumSbrPorts],
  output obi_rsp_t   sbr_ports_rsp_o [NumSbrPorts],
  output obi_req_t   mgr_port_req_o,
  input  obi_rsp_t   mgr_port_rsp_i,
  output logic [1:0] fault_o
);

  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSbrPorts - 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumMaxTrans - 1);
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumMaxTrans);

  if (ObiCfg.Integrity) begin : g_err_integrity
    $fatal(1, "relobi_rr_mux: ObiCfg.Integrity is not supported");
  end
  if (NumSbrPorts < 2) begin : g_err_ports
    $fatal(1, "relobi_rr_mux: NumSbrPorts must be at least 2");
  end
  if (NumMaxTrans < 1) begin : g_err_trans
    $fatal(1, "relobi_rr_mux: NumMaxTrans must be at least 1");
  end

  logic [2:0][IdxWidth-1:0]                  rr_q;
  logic [2:0][PtrWidth-1:0]                  wptr_q, rptr_q;
  logic [2:0][CntWidth-1:0]                  count_q;
  logic [2:0][NumMaxTrans-1:0][IdxWidth-1:0] fifo_q;

  logic [IdxWidth-1:0] rr_d;
  logic [PtrWidth-1:0] wptr_d, rptr_d;
  logic [CntWidth-1:0] count_d;

  logic [2:0][NumSbrPorts-1:0] req_vec;
  logic [2:0][IdxWidth-1:0]    win, head, rr_nxt;
  logic [2:0][PtrWidth-1:0]    wptr_nxt, rptr_nxt;
  logic [2:0][CntWidth-1:0]    cnt_nxt;
  logic [2:0]                  any_req, full, mgr_req, hs, nempty, pop, rready;
  logic [IdxWidth-1:0]         win_v, head_v;
  logic [PtrWidth-1:0]         wptr_v;
  logic                        hs_v, fault_vote, fault_empty;
  obi_r_chan_t                 r_bcast;

  assign r_bcast = mgr_port_rsp_i.r;

  // Descending scan so the lowest offset from rr_q wins the last overwrite.
  always_comb begin
    int p;
    p       = 0;
    req_vec = '0;
    win     = '0;
    any_req = '0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < int'(NumSbrPorts); k++) begin
        req_vec[i][k] = sbr_ports_req_i[k].req[i];
      end
      for (int o = int'(NumSbrPorts) - 1; o >= 0; o--) begin
        p = (int'(rr_q[i]) + o) % int'(NumSbrPorts);
        if (req_vec[i][p]) win[i] = IdxWidth'(p);
      end
      any_req[i] = |req_vec[i];
    end
  end

  always_comb begin
    full     = '0;
    nempty   = '0;
    mgr_req  = '0;
    hs       = '0;
    head     = '0;
    pop      = '0;
    rready   = 3'b111;
    rr_nxt   = rr_q;
    wptr_nxt = wptr_q;
    rptr_nxt = rptr_q;
    cnt_nxt  = count_q;

    for (int i = 0; i < 3; i++) begin
      full[i]    = (count_q[i] == MaxCnt);
      nempty[i]  = (count_q[i] != '0);
      mgr_req[i] = any_req[i] & ~full[i];
      hs[i]      = mgr_req[i] & mgr_port_rsp_i.gnt[i];
      head[i]    = fifo_q[i][rptr_q[i]];
    end

    win_v  = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
    head_v = (head[0] & head[1]) | (head[0] & head[2]) | (head[1] & head[2]);
    wptr_v = (wptr_q[0] & wptr_q[1]) | (wptr_q[0] & wptr_q[2]) | (wptr_q[1] & wptr_q[2]);
    hs_v   = (hs[0] & hs[1]) | (hs[0] & hs[2]) | (hs[1] & hs[2]);

    if (ObiCfg.UseRReady) begin
      rready = (head_v <= LastIdx) ? sbr_ports_req_i[head_v].rready : 3'b000;
    end

    for (int i = 0; i < 3; i++) begin
      pop[i] = mgr_port_rsp_i.rvalid[i] & rready[i] & nempty[i];
      if (hs[i]) begin
        rr_nxt[i]   = (win[i] >= LastIdx) ? '0 : win[i] + 1'b1;
        wptr_nxt[i] = (wptr_q[i] >= LastPtr) ? '0 : wptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rptr_nxt[i] = (rptr_q[i] >= LastPtr) ? '0 : rptr_q[i] + 1'b1;
      end
      case ({hs[i], pop[i]})
        2'b10:   cnt_nxt[i] = count_q[i] + 1'b1;
        2'b01:   cnt_nxt[i] = count_q[i] - 1'b1;
        default: cnt_nxt[i] = count_q[i];
      endcase
    end

    rr_d    = (rr_nxt[0] & rr_nxt[1]) | (rr_nxt[0] & rr_nxt[2]) | (rr_nxt[1] & rr_nxt[2]);
    wptr_d  = (wptr_nxt[0] & wptr_nxt[1]) | (wptr_nxt[0] & wptr_nxt[2]) |
              (wptr_nxt[1] & wptr_nxt[2]);
    rptr_d  = (rptr_nxt[0] & rptr_nxt[1]) | (rptr_nxt[0] & rptr_nxt[2]) |
              (rptr_nxt[1] & rptr_nxt[2]);
    count_d = (cnt_nxt[0] & cnt_nxt[1]) | (cnt_nxt[0] & cnt_nxt[2]) | (cnt_nxt[1] & cnt_nxt[2]);

    fault_vote = (rr_q[0] != rr_q[1])         | (rr_q[1] != rr_q[2])         |
                 (wptr_q[0] != wptr_q[1])     | (wptr_q[1] != wptr_q[2])     |
                 (rptr_q[0] != rptr_q[1])     | (rptr_q[1] != rptr_q[2])     |
                 (count_q[0] != count_q[1])   | (count_q[1] != count_q[2])   |
                 (rr_nxt[0] != rr_nxt[1])     | (rr_nxt[1] != rr_nxt[2])     |
                 (wptr_nxt[0] != wptr_nxt[1]) | (wptr_nxt[1] != wptr_nxt[2]) |
                 (rptr_nxt[0] != rptr_nxt[1]) | (rptr_nxt[1] != rptr_nxt[2]) |
                 (cnt_nxt[0] != cnt_nxt[1])   | (cnt_nxt[1] != cnt_nxt[2])   |
                 (win[0] != win[1])           | (win[1] != win[2])           |
                 (head[0] != head[1])         | (head[1] != head[2]);
    fault_empty = |(mgr_port_rsp_i.rvalid & ~nempty);
  end

  assign fault_o = {1'b0, fault_vote | fault_empty};

  // Grants are gated by the forwarded request so a full FIFO can never desynchronise a requester.
  always_comb begin
    mgr_port_req_o        = '0;
    mgr_port_req_o.a      = sbr_ports_req_i[(win_v <= LastIdx) ? win_v : '0].a;
    mgr_port_req_o.req    = mgr_req;
    mgr_port_req_o.rready = rready;
    for (int k = 0; k < int'(NumSbrPorts); k++) begin
      sbr_ports_rsp_o[k]   = '0;
      sbr_ports_rsp_o[k].r = r_bcast;
      for (int i = 0; i < 3; i++) begin
        sbr_ports_rsp_o[k].gnt[i]    = hs[i] & (win[i] == IdxWidth'(k));
        sbr_ports_rsp_o[k].rvalid[i] = mgr_port_rsp_i.rvalid[i] & nempty[i] &
                                       (head[i] == IdxWidth'(k));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fifo_q  <= '0;
    end else begin
      rr_q    <= {3{rr_d}};
      wptr_q  <= {3{wptr_d}};
      rptr_q  <= {3{rptr_d}};
      count_q <= {3{count_d}};
      if (hs_v && (wptr_v <= LastPtr)) begin
        for (int i = 0; i < 3; i++) begin
          fifo_q[i][wptr_v] <= win_v;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relobi_rr_mux.sv
`default_nettype none
// tb_relobi_rr_mux: directed scoreboard bench for relobi_rr_mux (3 ports, depth 2).
module tb_relobi_rr_mux;

  logic                 clk = 1'b0;
  logic                 rst_n;
  obi_pkg::relobi_req_t sbr_req [3];
  obi_pkg::relobi_rsp_t sbr_rsp [3];
  obi_pkg::relobi_req_t mgr_req;
  obi_pkg::relobi_rsp_t mgr_rsp;
  logic [1:0]           fault;

  int total = 0;
  int bad   = 0;
  int m_rr  = 0;
  int m_q [$];

  always #5 clk = ~clk;

  relobi_rr_mux #(
    .NumSbrPorts(3),
    .NumMaxTrans(2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sbr_ports_req_i(sbr_req),
    .sbr_ports_rsp_o(sbr_rsp),
    .mgr_port_req_o (mgr_req),
    .mgr_port_rsp_i (mgr_rsp),
    .fault_o        (fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rq, input logic g, input logic rv, input logic [31:0] rd);
    for (int k = 0; k < 3; k++) begin
      sbr_req[k].req    = {3{rq[k]}};
      sbr_req[k].a.addr = 32'h1000 + 32'(k * 16);
    end
    mgr_rsp.gnt     = {3{g}};
    mgr_rsp.rvalid  = {3{rv}};
    mgr_rsp.r.rdata = rd;
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model at the edge.
  task automatic cyc(input logic [2:0] rq, input logic g, input logic rv, input logic frc,
                     input string tag, output logic [8:0] gobs, output logic [8:0] robs);
    int          win;
    int          rvp;
    bit          any;
    bit          full;
    bit          hs;
    logic [31:0] rd;
    logic [8:0]  eg;
    logic [8:0]  er;
    logic [8:0]  msk;
    win  = -1;
    any  = |rq;
    full = (m_q.size() == 2);
    for (int o = 2; o >= 0; o--) begin
      if (rq[(m_rr + o) % 3]) win = (m_rr + o) % 3;
    end
    hs  = any && !full && g;
    rvp = (rv && m_q.size() > 0) ? m_q[0] : -1;
    rd  = $urandom;
    drive(rq, g, rv, rd);
    if (frc) force dut.rr_q = 6'b00_10_00;
    #3;
    eg  = '0;
    er  = '0;
    msk = frc ? 9'b101_101_101 : 9'b111_111_111;
    for (int k = 0; k < 3; k++) begin
      if (hs && win == k) eg[k*3 +: 3] = 3'b111;
      if (rvp == k)       er[k*3 +: 3] = 3'b111;
      gobs[k*3 +: 3] = sbr_rsp[k].gnt;
      robs[k*3 +: 3] = sbr_rsp[k].rvalid;
    end
    chk({tag, "_mreq"}, 64'(mgr_req.req), (any && !full) ? 64'd7 : 64'd0);
    chk({tag, "_gnt"}, 64'(gobs & msk), 64'(eg & msk));
    chk({tag, "_rvalid"}, 64'(robs), 64'(er));
    chk({tag, "_fault"}, 64'(fault), (frc || (rv && m_q.size() == 0)) ? 64'd1 : 64'd0);
    if (any && !full) chk({tag, "_addr"}, 64'(mgr_req.a.addr), 64'(32'h1000 + 32'(win * 16)));
    if (rvp >= 0) chk({tag, "_rdata"}, 64'(sbr_rsp[rvp].r.rdata), 64'(rd));
    if (frc) release dut.rr_q;
    @(posedge clk);
    #1;
    if (rvp >= 0) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(win);
      m_rr = (win + 1) % 3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] g;
    logic [8:0] r;
    int         order [6] = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 3; k++) sbr_req[k] = '0;
    mgr_rsp = '0;
    rst_n   = 1'b0;

    // Reset state
    #2;
    chk("rst_mreq", 64'(mgr_req.req), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_gnt", 64'({sbr_rsp[2].gnt, sbr_rsp[1].gnt, sbr_rsp[0].gnt}), 64'd0);
    chk("rst_cnt", 64'(dut.count_q), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester on port 1
    cyc(3'b010, 1'b1, 1'b0, 1'b0, "single0", g, r);
    chk("single0_p1gnt", 64'(g), 64'(9'b000_111_000));
    cyc(3'b010, 1'b1, 1'b1, 1'b0, "single1", g, r);
    cyc(3'b010, 1'b1, 1'b1, 1'b0, "single2", g, r);
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "single3", g, r);
    chk("single3_p1rv", 64'(r), 64'(9'b000_111_000));
    chk("single_cnt0", 64'(dut.count_q), 64'd0);

    // Out-of-order arrival: port 2 then port 0, responses follow grant order
    cyc(3'b100, 1'b1, 1'b0, 1'b0, "ooo0", g, r);
    cyc(3'b101, 1'b1, 1'b0, 1'b0, "ooo1", g, r);
    chk("ooo1_p0gnt", 64'(g), 64'(9'b000_000_111));
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "ooo2", g, r);
    chk("ooo2_p2rv", 64'(r), 64'(9'b111_000_000));
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "ooo3", g, r);
    chk("ooo3_p0rv", 64'(r), 64'(9'b000_000_111));

    // Backpressure at depth 2
    cyc(3'b011, 1'b1, 1'b0, 1'b0, "bp0", g, r);
    cyc(3'b011, 1'b1, 1'b0, 1'b0, "bp1", g, r);
    cyc(3'b011, 1'b1, 1'b0, 1'b0, "bp2_full", g, r);
    cyc(3'b011, 1'b1, 1'b1, 1'b0, "bp3_popfull", g, r);
    chk("bp3_p1rv", 64'(r), 64'(9'b000_111_000));
    cyc(3'b011, 1'b1, 1'b0, 1'b0, "bp4_resume", g, r);
    chk("bp4_p1gnt", 64'(g), 64'(9'b000_111_000));

    // Reset with two transactions outstanding
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #3;
    chk("mrst_cnt", 64'(dut.count_q), 64'd0);
    chk("mrst_fault", 64'(fault), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_q.delete();
    m_rr = 0;
    chk("mrst_cnt_rel", 64'(dut.count_q), 64'd0);
    cyc(3'b000, 1'b0, 1'b0, 1'b0, "mrst_idle", g, r);
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "empty_rv", g, r);
    chk("empty_rv_none", 64'(r), 64'd0);

    // Round-robin fairness with all ports requesting
    for (int i = 0; i < 6; i++) begin
      cyc(3'b111, 1'b1, (i > 0), 1'b0, "rr", g, r);
      chk("rr_order", 64'(g), 64'(9'b111 << (3 * order[i])));
    end
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "rr_drain", g, r);

    // Replica 1 arbitration pointer corrupted for one cycle
    cyc(3'b101, 1'b1, 1'b0, 1'b1, "inj", g, r);
    chk("inj_p0gnt_voted", 64'(g & 9'b000_000_101), 64'(9'b000_000_101));
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "inj_after", g, r);
    chk("inj_after_p0rv", 64'(r), 64'(9'b000_000_111));
    cyc(3'b111, 1'b1, 1'b0, 1'b0, "inj_next", g, r);
    chk("inj_next_p1gnt", 64'(g), 64'(9'b000_111_000));
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "inj_drain", g, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
